commit_ctrl: RTL and testbench
==============================

// Module: commit_ctrl
// PURPOSE
//   In-order retirement sequencer between the RoB head and the architectural register file.
//   Each cycle it inspects the RoB head and issues the register-file commit write (rob_id/rd/value).
//   It handshakes stores with the LSB, raises a multi-cycle flush on a branch mispredict,
//   and halts on the exit instruction.
// PARAMETERS
//   ROB_ID_W      4  width of RoB ids; id 0 means "no entry", valid ids are 1..2^ROB_ID_W-1
//   FLUSH_CYCLES  2  cycles flush stays high after a mispredict commit (>=1)
// PORTS
//   clk             in   1         clock
//   rst             in   1         synchronous reset, active-high
//   rdy             in   1         global enable; 0 = freeze
//   head_valid      in   1         RoB head entry exists
//   head_ready      in   1         RoB head result is available
//   head_rob_id     in   ROB_ID_W  RoB id of the head entry
//   head_type       in   2         0=REG, 1=STORE, 2=BRANCH (incl. JAL/JALR), 3=EXIT
//   head_rd         in   5         destination register (0 = none)
//   head_value      in   32        result or link value
//   head_mispredict in   1         BRANCH only: prediction was wrong
//   head_target_pc  in   32        BRANCH only: correct next pc
//   head_pop        out  1         combinational: RoB removes the head at this clock edge
//   commit_rob_id   out  ROB_ID_W  register-file write tag (0 = no commit)
//   commit_rd       out  5         register-file write destination
//   commit_value    out  32        register-file write data
//   store_req       out  1         LSB may perform the head store
//   store_rob_id    out  ROB_ID_W  RoB id of the requested store
//   store_done      in   1         LSB finished the store (1-cycle pulse)
//   flush           out  1         squash all speculative state
//   flush_pc        out  32        pc to refetch from
//   halted          out  1         sticky; exit instruction committed
//   commit_count    out  32        retired-instruction counter
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0. A reset mid-store or mid-flush aborts to IDLE.
// - rdy=0: every register holds and head_pop=0.
//   A commit_* pulse held across rdy=0 is consumed exactly once, at the next rdy=1 edge.
// - States: IDLE, STORE_WAIT, FLUSH, HALT.
// - commit_* are registered. They are nonzero for exactly one enabled cycle after the accept edge
//   and return to 0 otherwise.
// - IDLE, rdy=1, head_valid=1, head_ready=1:
//   REG: head_pop=1; next cycle commit_rob_id=head_rob_id and commit_rd=head_rd.
//     commit_value=head_value, forced to 0 when rd=0 so x0 stays 0.
//     Sustains 1 commit per cycle.
//   STORE: head_pop=0; store_req<=1 and store_rob_id<=head_rob_id; go to STORE_WAIT. No register write.
//   BRANCH without mispredict: same as REG (rd=0 yields a value-0 write to x0).
//   BRANCH with mispredict: head_pop=1 and the register commit as for REG.
//     flush<=1 and flush_pc<=head_target_pc for FLUSH_CYCLES cycles; go to FLUSH.
//   EXIT: head_pop=1; halted<=1; go to HALT.
//   If head_valid=0 or head_ready=0: no action.
// - STORE_WAIT: store_req stays 1. store_done=1 gives head_pop=1 in that same cycle.
//   At that edge store_req<=0 and the state returns to IDLE.
//   The next head is examined in the following cycle. store_done is ignored in all other states.
// - FLUSH: head_pop=0; a down-counter runs from FLUSH_CYCLES.
//   flush drops and the state returns to IDLE at the edge where the count expires.
//   flush_pc is held while flush=1 and is 0 otherwise.
// - HALT: absorbing until rst; head_pop=0; no further commits.
// - head_* must stay stable from accept until head_pop.
//   The RoB presents a new head only after a pop edge.
// - commit_count: +1 on every edge where head_pop=1; wraps modulo 2^32.
// TESTING
// - Back-to-back REG heads (id 1 rd 5 val 0xA), then (id 2 rd 6 val 0xB).
//   -> head_pop in 2 consecutive cycles; commit_* = (1,5,0xA) then (2,6,0xB); commit_count=2.
// - REG head with rd=0 and value 0x1234 -> commit_rob_id=id, commit_rd=0, commit_value=0.
// - STORE id 3, store_done asserted 4 cycles later.
//   -> store_req=1 and store_rob_id=3 for 4 cycles; head_pop only in the store_done cycle; no commit_*.
// - Mispredicted BRANCH id 4 rd 1 val 0x104 target 0x200, with FLUSH_CYCLES=2.
//   -> commit (4,1,0x104); flush=1 and flush_pc=0x200 for 2 cycles; a valid head during flush is not popped.
// - rdy low for 3 cycles right after a REG accept.
//   -> commit_* held, counters frozen; the pulse clears one cycle after rdy returns.
// - EXIT head, then valid REG heads -> halted=1 and stays 1; head_pop=0 thereafter.
//   rst clears halted and commit_count.

Source files
------------

// File: rtl/commit_ctrl.sv
// ----------------------------------------------------------------------------
// commit_ctrl
//   In-order retirement sequencer between the RoB head and the architectural
//   register file. It retires REG/BRANCH heads as a one-cycle register-file
//   write. It hands STORE heads to the LSB and waits for completion. A
//   mispredicted branch raises a multi-cycle flush. The EXIT instruction
//   halts the sequencer until reset.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | inspect RoB head, retire/accept when valid and ready
//   STORE_WAIT | store_req held, waiting for store_done from the LSB
//   FLUSH      | flush asserted, down-counter running to terminal count
//   HALT       | exit committed; absorbing until rst
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable (0 = every register holds, no pop)
//   head_*            RoB head entry (valid/ready/id/type/rd/value/mispredict/target)
//   head_pop          combinational: RoB removes the head at this edge
//   commit_*          registered one-cycle register-file write (id 0 = none)
//   store_req/_rob_id LSB store request for the head store
//   store_done        LSB completion pulse
//   flush/flush_pc    squash request and refetch pc
//   halted            sticky exit indication
//   commit_count      retired-instruction counter (wraps)
// ----------------------------------------------------------------------------
module commit_ctrl #(
    parameter int ROB_ID_W     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                head_valid,
    input  logic                head_ready,
    input  logic [ROB_ID_W-1:0] head_rob_id,
    input  logic [1:0]          head_type,
    input  logic [4:0]          head_rd,
    input  logic [31:0]         head_value,
    input  logic                head_mispredict,
    input  logic [31:0]         head_target_pc,
    output logic                head_pop,
    output logic [ROB_ID_W-1:0] commit_rob_id,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_value,
    output logic                store_req,
    output logic [ROB_ID_W-1:0] store_rob_id,
    input  logic                store_done,
    output logic                flush,
    output logic [31:0]         flush_pc,
    output logic                halted,
    output logic [31:0]         commit_count
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_STORE_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH      = 2'd2;
    localparam logic [1:0] S_HALT       = 2'd3;

    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [1:0] T_EXIT   = 2'd3;

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] flush_cnt;
    logic             accept;

    assign accept = (state == S_IDLE) && head_valid && head_ready;

    // Stores are not popped at accept; they pop on the LSB completion pulse.
    always_comb begin
        head_pop = 1'b0;
        if (rdy) begin
            if (accept && (head_type != T_STORE))
                head_pop = 1'b1;
            else if ((state == S_STORE_WAIT) && store_done)
                head_pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            flush_cnt     <= '0;
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            store_req     <= 1'b0;
            store_rob_id  <= '0;
            flush         <= 1'b0;
            flush_pc      <= '0;
            halted        <= 1'b0;
            commit_count  <= '0;
        end else if (rdy) begin
            // The commit pulse lasts one enabled cycle, so it clears here
            // unless a new retirement overwrites it below.
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;

            if (head_pop)
                commit_count <= commit_count + 32'd1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (head_type)
                            T_REG, T_BRANCH: begin
                                commit_rob_id <= head_rob_id;
                                commit_rd     <= head_rd;
                                // Keep x0 architecturally zero.
                                commit_value  <= (head_rd == 5'd0) ? 32'd0 : head_value;
                                if ((head_type == T_BRANCH) && head_mispredict) begin
                                    flush     <= 1'b1;
                                    flush_pc  <= head_target_pc;
                                    flush_cnt <= CNT_W'(FLUSH_CYCLES);
                                    state     <= S_FLUSH;
                                end
                            end
                            T_STORE: begin
                                store_req    <= 1'b1;
                                store_rob_id <= head_rob_id;
                                state        <= S_STORE_WAIT;
                            end
                            T_EXIT: begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_STORE_WAIT: begin
                    if (store_done) begin
                        store_req    <= 1'b0;
                        store_rob_id <= '0;
                        state        <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    // flush stays high for FLUSH_CYCLES cycles; it drops on
                    // the edge where the counter reaches its terminal count.
                    if (flush_cnt == CNT_W'(1)) begin
                        flush     <= 1'b0;
                        flush_pc  <= '0;
                        flush_cnt <= '0;
                        state     <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
module tb_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        head_valid;
    logic        head_ready;
    logic [3:0]  head_rob_id;
    logic [1:0]  head_type;
    logic [4:0]  head_rd;
    logic [31:0] head_value;
    logic        head_mispredict;
    logic [31:0] head_target_pc;
    logic        head_pop;
    logic [3:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        store_req;
    logic [3:0]  store_rob_id;
    logic        store_done;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halted;
    logic [31:0] commit_count;

    int checks = 0;
    int errors = 0;

    commit_ctrl #(.ROB_ID_W(4), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .head_valid      (head_valid),
        .head_ready      (head_ready),
        .head_rob_id     (head_rob_id),
        .head_type       (head_type),
        .head_rd         (head_rd),
        .head_value      (head_value),
        .head_mispredict (head_mispredict),
        .head_target_pc  (head_target_pc),
        .head_pop        (head_pop),
        .commit_rob_id   (commit_rob_id),
        .commit_rd       (commit_rd),
        .commit_value    (commit_value),
        .store_req       (store_req),
        .store_rob_id    (store_rob_id),
        .store_done      (store_done),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .halted          (halted),
        .commit_count    (commit_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic v, input logic [1:0] t, input logic [3:0] id,
                            input logic [4:0] rd, input logic [31:0] val,
                            input logic mp, input logic [31:0] tgt);
        head_valid      = v;
        head_ready      = v;
        head_type       = t;
        head_rob_id     = id;
        head_rd         = rd;
        head_value      = val;
        head_mispredict = mp;
        head_target_pc  = tgt;
    endtask

    task automatic clear_head();
        set_head(1'b0, 2'd0, 4'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; store_done = 1'b0;
        clear_head();
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({head_pop, commit_rob_id, commit_rd, commit_value} !== 42'd0) begin
            errors++;
            $display("FAIL reset_commit got pop=%0d id=%0d rd=%0d val=%h want all 0",
                     head_pop, commit_rob_id, commit_rd, commit_value);
        end
        checks++;
        if ({store_req, store_rob_id, flush, flush_pc, halted, commit_count} !== 71'd0) begin
            errors++;
            $display("FAIL reset_misc got sreq=%0d sid=%0d fl=%0d fpc=%h halt=%0d cnt=%0d want all 0",
                     store_req, store_rob_id, flush, flush_pc, halted, commit_count);
        end
    endtask

    task automatic test_back_to_back();
        set_head(1'b1, 2'd0, 4'd1, 5'd5, 32'hA, 1'b0, 32'd0);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++; $display("FAIL b2b_pop1 got %0d want 1", head_pop);
        end
        step();
        set_head(1'b1, 2'd0, 4'd2, 5'd6, 32'hB, 1'b0, 32'd0);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++; $display("FAIL b2b_pop2 got %0d want 1", head_pop);
        end
        checks++;
        if ({commit_rob_id, commit_rd, commit_value} !== {4'd1, 5'd5, 32'hA}) begin
            errors++;
            $display("FAIL b2b_commit1 got (%0d,%0d,%h) want (1,5,0000000a)",
                     commit_rob_id, commit_rd, commit_value);
        end
        step();
        clear_head();
        #1;
        checks++;
        if ({commit_rob_id, commit_rd, commit_value} !== {4'd2, 5'd6, 32'hB}) begin
            errors++;
            $display("FAIL b2b_commit2 got (%0d,%0d,%h) want (2,6,0000000b)",
                     commit_rob_id, commit_rd, commit_value);
        end
        checks++;
        if (commit_count !== 32'd2) begin
            errors++; $display("FAIL b2b_count got %0d want 2", commit_count);
        end
        step();
        checks++;
        if (commit_rob_id !== 4'd0) begin
            errors++; $display("FAIL b2b_clear got %0d want 0", commit_rob_id);
        end
    endtask

    task automatic test_rd_zero();
        set_head(1'b1, 2'd0, 4'd7, 5'd0, 32'h1234, 1'b0, 32'd0);
        step();
        clear_head();
        #1;
        checks++;
        if ({commit_rob_id, commit_rd, commit_value} !== {4'd7, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL rd0_commit got (%0d,%0d,%h) want (7,0,00000000)",
                     commit_rob_id, commit_rd, commit_value);
        end
        checks++;
        if (commit_count !== 32'd3) begin
            errors++; $display("FAIL rd0_count got %0d want 3", commit_count);
        end
        step();
    endtask

    task automatic test_store();
        set_head(1'b1, 2'd1, 4'd3, 5'd0, 32'h0, 1'b0, 32'd0);
        #1;
        checks++;
        if (head_pop !== 1'b0) begin
            errors++; $display("FAIL st_accept_pop got %0d want 0", head_pop);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            store_done = (i == 3);
            #1;
            checks++;
            if ({store_req, store_rob_id} !== {1'b1, 4'd3}) begin
                errors++;
                $display("FAIL st_req_c%0d got req=%0d id=%0d want req=1 id=3", i, store_req, store_rob_id);
            end
            checks++;
            if (head_pop !== (i == 3)) begin
                errors++; $display("FAIL st_pop_c%0d got %0d want %0d", i, head_pop, (i == 3));
            end
            checks++;
            if (commit_rob_id !== 4'd0) begin
                errors++; $display("FAIL st_nocommit_c%0d got %0d want 0", i, commit_rob_id);
            end
            step();
        end
        store_done = 1'b0;
        clear_head();
        #1;
        checks++;
        if ({store_req, commit_rob_id} !== 5'd0) begin
            errors++; $display("FAIL st_done got req=%0d cid=%0d want 0 0", store_req, commit_rob_id);
        end
        checks++;
        if (commit_count !== 32'd4) begin
            errors++; $display("FAIL st_count got %0d want 4", commit_count);
        end
        // store_done outside STORE_WAIT must be ignored
        store_done = 1'b1;
        #1;
        checks++;
        if (head_pop !== 1'b0) begin
            errors++; $display("FAIL st_stray_done got pop=%0d want 0", head_pop);
        end
        step();
        store_done = 1'b0;
        checks++;
        if (commit_count !== 32'd4) begin
            errors++; $display("FAIL st_stray_count got %0d want 4", commit_count);
        end
    endtask

    task automatic test_mispredict();
        set_head(1'b1, 2'd2, 4'd4, 5'd1, 32'h104, 1'b1, 32'h200);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++; $display("FAIL mp_pop got %0d want 1", head_pop);
        end
        step();
        set_head(1'b1, 2'd0, 4'd5, 5'd2, 32'h55, 1'b0, 32'd0);
        #1;
        checks++;
        if ({commit_rob_id, commit_rd, commit_value} !== {4'd4, 5'd1, 32'h104}) begin
            errors++;
            $display("FAIL mp_commit got (%0d,%0d,%h) want (4,1,00000104)",
                     commit_rob_id, commit_rd, commit_value);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({flush, flush_pc} !== {1'b1, 32'h200}) begin
                errors++; $display("FAIL mp_flush_c%0d got fl=%0d pc=%h want 1 00000200", i, flush, flush_pc);
            end
            checks++;
            if (head_pop !== 1'b0) begin
                errors++; $display("FAIL mp_nopop_c%0d got %0d want 0", i, head_pop);
            end
            step();
        end
        checks++;
        if ({flush, flush_pc} !== 33'd0) begin
            errors++; $display("FAIL mp_flush_end got fl=%0d pc=%h want 0 0", flush, flush_pc);
        end
        checks++;
        if (head_pop !== 1'b1) begin
            errors++; $display("FAIL mp_resume_pop got %0d want 1", head_pop);
        end
        checks++;
        if (commit_count !== 32'd5) begin
            errors++; $display("FAIL mp_count got %0d want 5", commit_count);
        end
        step();
        clear_head();
        #1;
        checks++;
        if ({commit_rob_id, commit_rd, commit_value, commit_count} !== {4'd5, 5'd2, 32'h55, 32'd6}) begin
            errors++;
            $display("FAIL mp_next got (%0d,%0d,%h) cnt=%0d want (5,2,00000055) cnt=6",
                     commit_rob_id, commit_rd, commit_value, commit_count);
        end
        step();
    endtask

    task automatic test_branch_ok();
        set_head(1'b1, 2'd2, 4'd6, 5'd0, 32'h99, 1'b0, 32'h300);
        step();
        clear_head();
        #1;
        checks++;
        if ({commit_rob_id, commit_rd, commit_value, flush} !== {4'd6, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL br_ok got (%0d,%0d,%h) fl=%0d want (6,0,00000000) fl=0",
                     commit_rob_id, commit_rd, commit_value, flush);
        end
        checks++;
        if (commit_count !== 32'd7) begin
            errors++; $display("FAIL br_count got %0d want 7", commit_count);
        end
        step();
    endtask

    task automatic test_rdy_freeze();
        set_head(1'b1, 2'd0, 4'd8, 5'd3, 32'h00C0FFEE, 1'b0, 32'd0);
        step();
        clear_head();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({commit_rob_id, commit_rd, commit_value, commit_count} !== {4'd8, 5'd3, 32'h00C0FFEE, 32'd8}) begin
                errors++;
                $display("FAIL frz_hold_c%0d got (%0d,%0d,%h) cnt=%0d want (8,3,00c0ffee) cnt=8",
                         i, commit_rob_id, commit_rd, commit_value, commit_count);
            end
        end
        rdy = 1'b1;
        step();
        checks++;
        if ({commit_rob_id, commit_count} !== {4'd0, 32'd8}) begin
            errors++; $display("FAIL frz_release got id=%0d cnt=%0d want 0 8", commit_rob_id, commit_count);
        end
        // a valid head must not pop while frozen
        set_head(1'b1, 2'd0, 4'd9, 5'd4, 32'h77, 1'b0, 32'd0);
        rdy = 1'b0;
        #1;
        checks++;
        if (head_pop !== 1'b0) begin
            errors++; $display("FAIL frz_pop got %0d want 0", head_pop);
        end
        step();
        rdy = 1'b1;
        #1;
        checks++;
        if ({head_pop, commit_rob_id} !== {1'b1, 4'd0}) begin
            errors++; $display("FAIL frz_accept got pop=%0d id=%0d want 1 0", head_pop, commit_rob_id);
        end
        step();
        clear_head();
        #1;
        checks++;
        if ({commit_rob_id, commit_value, commit_count} !== {4'd9, 32'h77, 32'd9}) begin
            errors++;
            $display("FAIL frz_commit got id=%0d val=%h cnt=%0d want 9 00000077 9",
                     commit_rob_id, commit_value, commit_count);
        end
        step();
    endtask

    task automatic test_halt();
        set_head(1'b1, 2'd3, 4'd10, 5'd0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++; $display("FAIL ex_pop got %0d want 1", head_pop);
        end
        step();
        set_head(1'b1, 2'd0, 4'd11, 5'd7, 32'h1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({halted, head_pop, commit_rob_id, commit_count} !== {1'b1, 1'b0, 4'd0, 32'd10}) begin
                errors++;
                $display("FAIL ex_halt_c%0d got halt=%0d pop=%0d id=%0d cnt=%0d want 1 0 0 10",
                         i, halted, head_pop, commit_rob_id, commit_count);
            end
            step();
        end
        clear_head();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({halted, commit_count} !== 33'd0) begin
            errors++; $display("FAIL ex_rst got halt=%0d cnt=%0d want 0 0", halted, commit_count);
        end
    endtask

    task automatic test_reset_abort();
        set_head(1'b1, 2'd1, 4'd12, 5'd0, 32'd0, 1'b0, 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        store_done = 1'b1;
        #1;
        checks++;
        if ({store_req, store_rob_id, head_pop} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_abort got req=%0d id=%0d pop=%0d want 0 0 0", store_req, store_rob_id, head_pop);
        end
        store_done = 1'b0;
        clear_head();
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rd_zero();
        test_store();
        test_mispredict();
        test_branch_ok();
        test_rdy_freeze();
        test_halt();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
